// File: rtl/ball_pkg.sv
// Shared defaults, per-axis command type and symmetric velocity saturation
// used by the ball motion logic.
package ball_pkg;

  localparam int unsigned TICK_M_DEFAULT = 1350000;
  localparam int unsigned START_X        = 128;
  localparam int unsigned START_Y        = 188;

  typedef enum logic [1:0] {AX_NONE, AX_POS, AX_NEG} axis_cmd_e;

  // a + b clamped to [-lim, lim]; the most-negative code is never produced.
  function automatic int sat_add(int a, int b, int lim);
    int s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/ball_kinematics_if.sv
// Direction/wall inputs and position/velocity outputs of the ball motion block.
interface ball_kinematics_if #(
  parameter int unsigned POS_W = 8,
  parameter int unsigned VEL_W = 5
);
  logic                    up, down, left, right;
  logic                    wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball;
  logic [POS_W-1:0]        ballColumn, ballRow;
  logic signed [VEL_W-1:0] xVelocity, yVelocity;
  logic                    posUpdate;

  modport master (
    output up, down, left, right,
    output wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball,
    input  ballColumn, ballRow, xVelocity, yVelocity, posUpdate
  );

  modport slave (
    input  up, down, left, right,
    input  wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball,
    output ballColumn, ballRow, xVelocity, yVelocity, posUpdate
  );
endinterface

// File: rtl/ball_axis.sv
// One motion axis: velocity update on tick (stage 1), then fixed-point position
// update with wall stop/reflect and screen-edge clamping (stage 2).
module ball_axis
  import ball_pkg::*;
#(
  parameter int unsigned POS_W    = 8,
  parameter int unsigned FRAC_W   = 2,
  parameter int unsigned VEL_W    = 5,
  parameter int unsigned VMAX     = 15,
  parameter int unsigned ACC_STEP = 1,
  parameter int unsigned START    = 128,
  parameter bit          BOUNCE   = 1'b0,
  parameter bit          FRICTION = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick_i,
  input  logic                    upd_i,
  input  axis_cmd_e               cmd_i,
  input  logic                    wall_pos_i,
  input  logic                    wall_neg_i,
  output logic [POS_W-1:0]        pos_o,
  output logic signed [VEL_W-1:0] vel_o
);

  localparam int unsigned FX_W = POS_W + FRAC_W;

  logic [FX_W-1:0]         pos_q, pos_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic signed [FX_W+1:0]  sum;
  int                      v_int;

  always_comb begin
    pos_d = pos_q;
    vel_d = vel_q;
    v_int = int'(vel_q);
    // Two guard bits above the position so both underflow and overflow are visible.
    sum   = $signed({2'b00, pos_q}) + $signed({{(FX_W + 2 - VEL_W){vel_q[VEL_W-1]}}, vel_q});
    if (tick_i) begin
      case (cmd_i)
        AX_POS:  vel_d = VEL_W'(sat_add(v_int, int'(ACC_STEP), int'(VMAX)));
        AX_NEG:  vel_d = VEL_W'(sat_add(v_int, -int'(ACC_STEP), int'(VMAX)));
        default: begin
          if (FRICTION && v_int != 0) vel_d = VEL_W'((v_int > 0) ? v_int - 1 : v_int + 1);
        end
      endcase
    end else if (upd_i) begin
      if ((v_int > 0 && wall_pos_i) || (v_int < 0 && wall_neg_i)) begin
        vel_d = BOUNCE ? -vel_q : '0;
      end else if (sum[FX_W+1]) begin
        pos_d = '0;
        vel_d = '0;
      end else if (sum[FX_W]) begin
        pos_d = '1;
        vel_d = '0;
      end else begin
        pos_d = sum[FX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= {POS_W'(START), {FRAC_W{1'b0}}};
      vel_q <= '0;
    end else begin
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  end

  assign pos_o = pos_q[FX_W-1 -: POS_W];
  assign vel_o = vel_q;

endmodule

// File: rtl/ball_kinematics.sv
// Ball motion top: motion tick divider, direction decode and the two axis
// pipelines; posUpdate marks the cycle new positions appear.
module ball_kinematics #(
  parameter int unsigned POS_W    = 8,
  parameter int unsigned FRAC_W   = 2,
  parameter int unsigned VEL_W    = 5,
  parameter int unsigned VMAX     = 15,
  parameter int unsigned ACC_STEP = 1,
  parameter int unsigned TICK_M   = ball_pkg::TICK_M_DEFAULT,
  parameter int unsigned START_X  = ball_pkg::START_X,
  parameter int unsigned START_Y  = ball_pkg::START_Y,
  parameter bit          BOUNCE   = 1'b0,
  parameter bit          FRICTION = 1'b1
) (
  input logic               clk108MHz,
  input logic               resetPressed,
  ball_kinematics_if.slave  bus_io
);
  import ball_pkg::*;

  localparam int unsigned CNT_W = (TICK_M > 1) ? $clog2(TICK_M) : 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    tick;
  logic                    s1_valid_q, s1_valid_d;
  logic                    pos_update_q, pos_update_d;
  axis_cmd_e               x_cmd, y_cmd;
  logic [POS_W-1:0]        col, row;
  logic signed [VEL_W-1:0] x_vel, y_vel;

  always_comb begin
    tick         = (cnt_q == CNT_W'(TICK_M - 1));
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    s1_valid_d   = tick;
    pos_update_d = s1_valid_q;
    // Opposing requests cancel and behave like no request.
    x_cmd = AX_NONE;
    if (bus_io.right && !bus_io.left) x_cmd = AX_POS;
    else if (bus_io.left && !bus_io.right) x_cmd = AX_NEG;
    y_cmd = AX_NONE;
    if (bus_io.down && !bus_io.up) y_cmd = AX_POS;
    else if (bus_io.up && !bus_io.down) y_cmd = AX_NEG;
  end

  always_ff @(posedge clk108MHz) begin
    if (resetPressed) begin
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      pos_update_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      pos_update_q <= pos_update_d;
    end
  end

  ball_axis #(
    .POS_W(POS_W), .FRAC_W(FRAC_W), .VEL_W(VEL_W), .VMAX(VMAX), .ACC_STEP(ACC_STEP),
    .START(START_X), .BOUNCE(BOUNCE), .FRICTION(FRICTION)
  ) u_axis_x (
    .clk_i(clk108MHz), .rst_i(resetPressed), .tick_i(tick), .upd_i(s1_valid_q),
    .cmd_i(x_cmd), .wall_pos_i(bus_io.wallRightOfball), .wall_neg_i(bus_io.wallLeftOfball),
    .pos_o(col), .vel_o(x_vel)
  );

  ball_axis #(
    .POS_W(POS_W), .FRAC_W(FRAC_W), .VEL_W(VEL_W), .VMAX(VMAX), .ACC_STEP(ACC_STEP),
    .START(START_Y), .BOUNCE(BOUNCE), .FRICTION(FRICTION)
  ) u_axis_y (
    .clk_i(clk108MHz), .rst_i(resetPressed), .tick_i(tick), .upd_i(s1_valid_q),
    .cmd_i(y_cmd), .wall_pos_i(bus_io.wallBelowball), .wall_neg_i(bus_io.wallAboveball),
    .pos_o(row), .vel_o(y_vel)
  );

  assign bus_io.ballColumn = col;
  assign bus_io.ballRow    = row;
  assign bus_io.xVelocity  = x_vel;
  assign bus_io.yVelocity  = y_vel;
  assign bus_io.posUpdate  = pos_update_q;

endmodule
